// File: rtl/pin_uart_rx.sv
// pin_uart_rx: 8N1 receiver with 3-sample majority vote; define PIN_RX_FIFO_EN for a 2^FIFO_AW-entry FIFO instead of a holding register
module pin_uart_rx #(
  parameter int CLKS_PER_BIT = 2605,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_pin,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic [15:0] byte_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t state, nxt;
  logic s1, line, vote, at, push, ferr, full, pop, store;
  logic [1:0] hist;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic [15:0] bcnt;
  // hist holds line at center-1 and center; the live line is center+1
  assign vote = (hist[1] & hist[0]) | (line & (hist[1] | hist[0]));
  assign at = cnt == (state == START ? HALF : LAST);
  assign pop = m_valid & m_ready;
  assign store = push & (~full | pop);
  assign byte_count = bcnt;
  always_comb begin
    nxt = state;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE:    nxt = line ? IDLE : START;
      START:   nxt = at ? (vote ? IDLE : DATA) : START;
      DATA:    nxt = (at && bit_idx == 3'd7) ? STOP : DATA;
      STOP: begin
        nxt = at ? (vote ? IDLE : WAIT_HI) : STOP;
        push = at & vote;
        ferr = at & ~vote;
      end
      WAIT_HI: nxt = line ? IDLE : WAIT_HI;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      line <= 1'b1;
      hist <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      bcnt <= '0;
    end else begin
      s1 <= rx_pin;
      line <= s1;
      hist <= {hist[0], line};
      state <= nxt;
      cnt <= (nxt != state || at) ? '0 : cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && at) bit_idx <= bit_idx + 3'd1;
      if (state == DATA && at) sh <= {vote, sh[7:1]};
      frame_err <= ferr;
      overrun <= push & full & ~pop;
      if (store) bcnt <= bcnt + 16'd1;
    end
  end
`ifdef PIN_RX_FIFO_EN
  logic [7:0] mem [1 << FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  assign m_valid = wp != rp;
  assign full = (wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}};
  assign m_data = m_valid ? mem[rp[FIFO_AW-1:0]] : 8'h00;
  always_ff @(posedge clk) if (store) mem[wp[FIFO_AW-1:0]] <= sh;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (FIFO_AW+1)'(store);
      rp <= rp + (FIFO_AW+1)'(pop);
    end
  end
`else
  logic [7:0] hold;
  logic hv;
  assign m_valid = hv;
  assign m_data = hold;
  assign full = hv & ~m_ready & (FIFO_AW >= 0);
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      hv <= 1'b0;
    end else if (store) begin
      hold <= sh;
      hv <= 1'b1;
    end else if (pop) begin
      hv <= 1'b0;
    end
  end
`endif
endmodule
